alu_cmd_issuer: RTL

Command queue and issue sequencer that sits directly upstream of the multicycle ALU/register-file stage. It buffers packed ALU commands and presents each one to the ALU for exactly one FETCH→EXECUTE→WRITEBACK slot, holding all operands stable for the whole slot. When no command is pending it drives a NOP. On completion it captures the ALU result and carry into a one-cycle result strobe for the downstream consumer.

---
 rtl/alu_cmd_issuer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//
// Command queue and issue sequencer sitting in front of the multicycle
// ALU/register-file stage. Packed commands are buffered in a small circular
// FIFO. Each command is presented to the ALU for exactly one three-cycle
// FETCH -> EXECUTE -> WRITEBACK slot, with all operands held stable for
// the whole slot. A NOP is driven whenever no command is pending. When the
// ALU signals WRITEBACK for a real command, its result and carry are
// captured into a one-cycle result strobe.
//
// Parameters
//   DEPTH          command FIFO entries (power of two, >= 2)
//
// Ports
//   clk            clock, rising-edge active
//   reset          asynchronous, active-high reset (shared with the ALU)
//   cmd_valid      upstream offers cmd_data this cycle
//   cmd_ready      FIFO not full; push when cmd_valid && cmd_ready
//   cmd_data       {reg_write, reg_addr[1:0], ctrl[1:0], a[1:0], b[1:0]}
//   alu_a, alu_b   ALU operands
//   alu_ctrl       ALU op: 00 add, 01 sub, 10 mul, 11 div
//   alu_reg_addr   register-file destination
//   alu_reg_write  register-file write enable
//   alu_y          ALU result
//   alu_c          ALU carry/error flag
//   alu_done       ALU WRITEBACK indicator
//   res_valid      one-cycle pulse: a real command's result was captured
//   res_y, res_c   captured result and carry/error (held between pulses)
//   fifo_count     number of queued commands
//   issued_count   completed real commands, wraps 255 -> 0
//   sync_err       sticky flag: slot phase and alu_done disagreed
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [8:0]               cmd_data,
    output logic [1:0]               alu_a,
    output logic [1:0]               alu_b,
    output logic [1:0]               alu_ctrl,
    output logic [1:0]               alu_reg_addr,
    output logic                     alu_reg_write,
    input  logic [3:0]               alu_y,
    input  logic                     alu_c,
    input  logic                     alu_done,
    output logic                     res_valid,
    output logic [3:0]               res_y,
    output logic                     res_c,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               issued_count,
    output logic                     sync_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Slot phases mirror the ALU's own state machine.
    localparam logic [1:0] PH_FETCH     = 2'd0;
    localparam logic [1:0] PH_EXECUTE   = 2'd1;
    localparam logic [1:0] PH_WRITEBACK = 2'd2;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] reg_addr;
        logic [1:0] ctrl;
        logic [1:0] a;
        logic [1:0] b;
    } cmd_t;

    localparam cmd_t NOP_CMD = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cmd_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [1:0]      phase;
    logic [1:0]      phase_next;
    logic            slot_live;
    cmd_t            slot_cmd;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            slot_load;
    logic            capture;
    logic            phase_mismatch;
    cmd_t            head;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign cmd_ready  = (fifo_count != FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr];

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        phase_next = phase + 2'd1;
        if (alu_done || (phase == PH_WRITEBACK)) begin
            phase_next = PH_FETCH;
        end
    end

    // A new slot starts on every edge that returns the phase to FETCH,
    // including an early return forced by a premature alu_done.
    assign slot_load = (phase_next == PH_FETCH);
    assign pop       = slot_load && !fifo_empty;
    assign capture   = alu_done && slot_live;

    // alu_done must be high exactly in the WRITEBACK cycle; anything else
    // means we and the ALU disagree about where the slot boundary is.
    assign phase_mismatch = alu_done != (phase == PH_WRITEBACK);

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; the pointers and
    // occupancy count alone decide which entries hold valid commands.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_t'(cmd_data);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slot sequencing: phase counter and the held ALU command
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= PH_FETCH;
            slot_live <= 1'b0;
            slot_cmd  <= NOP_CMD;
        end else begin
            phase <= phase_next;
            if (slot_load) begin
                if (!fifo_empty) begin
                    slot_cmd  <= head;
                    slot_live <= 1'b1;
                end else begin
                    slot_cmd  <= NOP_CMD;
                    slot_live <= 1'b0;
                end
            end
        end
    end

    assign alu_reg_write = slot_cmd.reg_write;
    assign alu_reg_addr  = slot_cmd.reg_addr;
    assign alu_ctrl      = slot_cmd.ctrl;
    assign alu_a         = slot_cmd.a;
    assign alu_b         = slot_cmd.b;

    // ------------------------------------------------------------------
    // Result capture and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid    <= 1'b0;
            res_y        <= '0;
            res_c        <= 1'b0;
            issued_count <= '0;
            sync_err     <= 1'b0;
        end else begin
            res_valid <= capture;
            if (capture) begin
                res_y        <= alu_y;
                res_c        <= alu_c;
                issued_count <= issued_count + 8'd1;
            end
            if (phase_mismatch) begin
                sync_err <= 1'b1;
            end
        end
    end

    // PH_EXECUTE is only reached through the +1 step; named for readability.
    logic unused_phase_name;
    assign unused_phase_name = (PH_EXECUTE == 2'd1);

endmodule
